dq_load_sequencer: RTL and testbench
====================================

# dq_load_sequencer

Upstream driver for the gated D-latch bank (DQ4 array). Accepts words over a valid/ready handshake, buffers one word, and replays each word onto the latch inputs as a timed setup → enable-pulse → hold sequence. The latch data never changes while its enable is high. Sits directly in front of the latch bank: `lat_d` and `lat_en` wire straight to its `d` and `en` inputs.

## Interface
- `WIDTH`, 4: data width; must equal the latch-bank width.
- `SETUP`, 1: cycles `lat_d` is stable before `lat_en` rises; range 1..255.
- `PULSE`, 1: cycles `lat_en` is held high; range 1..255.
- `HOLD`, 1: cycles `lat_d` is held stable after `lat_en` falls; range 1..255.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  WIDTH: word to be latched.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: a word is accepted on an edge where `in_valid && in_ready`.
- `lat_d`  out  WIDTH: latch data, registered.
- `lat_en`  out  1: latch enable, registered, glitch-free.
- `busy`  out  1: high whenever state ≠ IDLE or the pending buffer is full.
- `load_count`  out  8: number of completed enable pulses, modulo 256.

## Operation
- Pending buffer: one entry (`pend_data`, `pend_valid`).
  - `in_ready = !pend_valid` (combinational from the register).
  - On accept, `pend_data <= in_data` and `pend_valid <= 1`.
- Sequencer states: IDLE, SETUP, PULSE, HOLD. A down-counter `cnt` (8 bits) times each phase.
- IDLE with `pend_valid`:
  - `lat_d <= pend_data`, `pend_valid <= 0`.
  - Go to SETUP with `cnt <= SETUP-1`.
- IDLE without `pend_valid`: remain in IDLE; outputs hold.
- SETUP: `lat_en` stays 0. When `cnt == 0`, go to PULSE with `lat_en <= 1` and `cnt <= PULSE-1`; otherwise decrement `cnt`.
- PULSE: `lat_en` stays 1. When `cnt == 0`, go to HOLD with `lat_en <= 0`, `cnt <= HOLD-1`, and `load_count <= load_count + 1` (wraps 255 → 0).
- HOLD: `lat_en` stays 0 and `lat_d` is unchanged. When `cnt == 0`:
  - If `pend_valid`, behave exactly as IDLE-with-pending (load the next word, go to SETUP). This is the back-to-back path; no IDLE cycle is inserted.
  - Otherwise go to IDLE.
- `lat_d` is written only on the IDLE/HOLD → SETUP transition. It never changes in PULSE or HOLD.
- Simultaneous events:
  - A word that transfers from pend to `lat_d` on edge N cannot be replaced on edge N, because `in_ready` was low.
  - `in_ready` rises in the cycle after the transfer.
- `in_data` is ignored whenever `in_ready` is 0. A sender holding `in_valid` keeps its word until it is accepted.
- Reset, including mid-sequence: on the edge where `rst` is high:
  - state IDLE, `cnt` 0
  - `lat_en` 0, `lat_d` 0
  - `pend_valid` 0, `load_count` 0
  - A pulse in progress is truncated; a truncated pulse is not counted.
  - While `rst` is high, `in_ready` is 1 but no word is accepted.

## Timing
- Reset values: `lat_d`=0, `lat_en`=0, `in_ready`=1, `busy`=0, `load_count`=0.
- Default parameters, single word accepted on edge 0:
  - Edge 1: `lat_d` updates.
  - Edge 2: `lat_en` rises.
  - Edge 3: `lat_en` falls; `load_count` increments.
  - Edge 4: IDLE (or SETUP of the next word); `busy` low after edge 4 if no further word.
- General schedule:
  - Latency, accept edge → `lat_en` rise: 1 + SETUP edges.
  - `lat_en` high for exactly PULSE cycles.
  - `lat_d` stable for SETUP + PULSE + HOLD cycles.
- Sustained throughput: one word per SETUP + PULSE + HOLD cycles, provided the pending buffer refills during the sequence.
- `in_ready` low from the accept edge until the edge on which the word transfers to `lat_d`.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, then `in_valid`=0 for 10 cycles → `lat_en`=0, `lat_d`=0000, `in_ready`=1, `busy`=0, `load_count`=0 throughout.
- Single word, defaults: 0101 accepted at edge 0 → `lat_d`=0101 after edge 1, `lat_en` high exactly between edges 2–3, `load_count`=1, `busy`=0 after edge 4.
- Stream: `in_valid` held high, `in_data` stepping 0000..1111 on each accept → 16 enable pulses 3 cycles apart, `lat_d` sequence 0..15 with no change while `lat_en`=1, `load_count`=16.
- Non-default timing: SETUP=2, PULSE=3, HOLD=2, word 1010 → `lat_en` rises 3 edges after accept, stays high 3 cycles, `lat_d` stable for 7 cycles.
- Reset mid-pulse: assert `rst` during the second PULSE cycle (PULSE=3) → next edge `lat_en`=0, `lat_d`=0000, `load_count`=0, `in_ready`=1; the next accepted word runs a full sequence.
- Counter wrap: 257 words → `load_count` reads 255 after pulse 255, 0 after pulse 256, 1 after pulse 257.

Source files
------------

// File: rtl/dq_load_sequencer.sv
// Front-end driver for the DQ4 gated-latch bank: one-word input buffer feeding a
// setup -> enable-pulse -> hold replay sequencer with a wrapping pulse counter.
module dq_load_sequencer #(
  parameter int WIDTH = 4,
  parameter int SETUP = 1,
  parameter int PULSE = 1,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  output logic             busy,
  output logic [7:0]       load_count
);

  typedef enum logic [1:0] {
    stIdle,
    stSetup,
    stPulse,
    stHold
  } seqState_t;

  localparam logic [7:0] setupLoad = 8'(SETUP - 1);
  localparam logic [7:0] pulseLoad = 8'(PULSE - 1);
  localparam logic [7:0] holdLoad  = 8'(HOLD - 1);

  seqState_t        state;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] pendData;
  logic             pendValid;

  assign in_ready = !pendValid;
  assign busy     = (state != stIdle) || pendValid;

  // NOTE: all state uses non-blocking assignments so every register sees the
  // pre-edge values of the others, regardless of statement order.
  // NOTE: pendData is deliberately left out of reset; pendValid qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= stIdle;
      cnt        <= 8'd0;
      lat_en     <= 1'b0;
      lat_d      <= '0;
      pendValid  <= 1'b0;
      load_count <= 8'd0;
    end else begin
      // Accept and transfer are mutually exclusive: accept needs an empty
      // buffer, transfer needs a full one.
      if (in_valid && !pendValid) begin
        pendData  <= in_data;
        pendValid <= 1'b1;
      end

      case (state)
        stIdle: begin
          if (pendValid) begin
            lat_d     <= pendData;
            pendValid <= 1'b0;
            cnt       <= setupLoad;
            state     <= stSetup;
          end
        end

        stSetup: begin
          if (cnt == 8'd0) begin
            lat_en <= 1'b1;
            cnt    <= pulseLoad;
            state  <= stPulse;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        stPulse: begin
          if (cnt == 8'd0) begin
            lat_en     <= 1'b0;
            cnt        <= holdLoad;
            load_count <= load_count + 8'd1;
            state      <= stHold;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        stHold: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (pendValid) begin
            // Back-to-back path: start the next word without an idle cycle.
            lat_d     <= pendData;
            pendValid <= 1'b0;
            cnt       <= setupLoad;
            state     <= stSetup;
          end else begin
            state <= stIdle;
          end
        end

        default: state <= stIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dq_load_sequencer.sv
// Directed bench for dq_load_sequencer: a default-timing instance and a
// SETUP=2/PULSE=3/HOLD=2 instance, checked against hand-derived schedules.
module tb_dq_load_sequencer;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [3:0] data0, data1;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic [3:0] latD0, latD1;
  logic       latEn0, latEn1;
  logic       busy0, busy1;
  logic [7:0] count0, count1;

  int nVectors    = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  dq_load_sequencer u0 (
    .clk(clk), .rst(rst0), .in_data(data0), .in_valid(valid0), .in_ready(ready0),
    .lat_d(latD0), .lat_en(latEn0), .busy(busy0), .load_count(count0)
  );

  dq_load_sequencer #(.WIDTH(4), .SETUP(2), .PULSE(3), .HOLD(2)) u1 (
    .clk(clk), .rst(rst1), .in_data(data1), .in_valid(valid1), .in_ready(ready1),
    .lat_d(latD1), .lat_en(latEn1), .busy(busy1), .load_count(count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge, so exactly one
  // rising edge separates consecutive ticks.
  task automatic tick();
    @(negedge clk);
  endtask

  // One word through the non-default instance; edge 0 is the accept edge.
  task automatic runWordU1(input logic [3:0] w, input logic [7:0] countAfter);
    data1  = w;
    valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    check("u1 ready after accept", ready1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("u1 en edge%0d", k), latEn1, (k >= 3 && k <= 5));
      check($sformatf("u1 d edge%0d", k), latD1, w);
      check($sformatf("u1 busy edge%0d", k), busy1, (k < 8));
    end
    check("u1 count after word", count1, countAfter);
  endtask

  // Hold in_valid high and feed n words of incrementing data into u0.
  task automatic runStream(input int n, input bit wrapChecks);
    int   sent     = 0;
    int   pulses   = 0;
    int   lastRise = -1;
    int   cyc      = 0;
    logic prevEn   = 1'b0;
    logic readyNow;
    while (!(pulses == n && !busy0) && cyc < n * 3 + 40) begin
      data0    = sent[3:0];
      valid0   = (sent < n);
      readyNow = ready0;
      tick();
      cyc++;
      if (readyNow && valid0) sent++;
      if (latEn0 && !prevEn) begin
        if (!wrapChecks) begin
          check("stream d at rise", latD0, pulses[3:0]);
          if (lastRise >= 0) check("stream pulse spacing", cyc - lastRise, 3);
        end
        lastRise = cyc;
      end
      if (!latEn0 && prevEn) begin
        pulses++;
        if (!wrapChecks) check("stream d held after fall", latD0, pulses - 1);
        else if (pulses >= 255) check($sformatf("wrap count p%0d", pulses), count0, pulses % 256);
      end
      prevEn = latEn0;
    end
    check("stream pulses done", pulses, n);
    check("stream final busy", busy0, 1'b0);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    valid0 = 1'b0; valid1 = 1'b0;
    data0 = 4'h0; data1 = 4'h0;

    // Reset then idle.
    tick(); tick();
    rst0 = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle en", latEn0, 1'b0);
      check("idle d", latD0, 4'h0);
      check("idle ready", ready0, 1'b1);
      check("idle busy", busy0, 1'b0);
      check("idle count", count0, 8'd0);
    end

    // Single word 0101 on default timing.
    data0 = 4'b0101; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    check("single ready e0", ready0, 1'b0);
    check("single busy e0", busy0, 1'b1);
    check("single d e0", latD0, 4'h0);
    tick();
    check("single d e1", latD0, 4'b0101);
    check("single en e1", latEn0, 1'b0);
    check("single ready e1", ready0, 1'b1);
    tick();
    check("single en e2", latEn0, 1'b1);
    check("single count e2", count0, 8'd0);
    tick();
    check("single en e3", latEn0, 1'b0);
    check("single count e3", count0, 8'd1);
    check("single busy e3", busy0, 1'b1);
    check("single d e3", latD0, 4'b0101);
    tick();
    check("single busy e4", busy0, 1'b0);

    // Stream of 16 words after a fresh reset.
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    check("stream pre count", count0, 8'd0);
    runStream(16, 1'b0);
    check("stream count", count0, 8'd16);
    check("stream last d", latD0, 4'hF);

    // Non-default timing, word 1010.
    runWordU1(4'b1010, 8'd1);

    // Reset during the second pulse cycle of u1.
    data1 = 4'b0011; valid1 = 1'b1;
    tick(); valid1 = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check("midreset en before", latEn1, 1'b1);
    rst1 = 1'b1; valid1 = 1'b1; data1 = 4'hF;
    tick();
    check("midreset en", latEn1, 1'b0);
    check("midreset d", latD1, 4'h0);
    check("midreset count", count1, 8'd0);
    check("midreset ready", ready1, 1'b1);
    check("midreset busy", busy1, 1'b0);
    rst1 = 1'b0;
    runWordU1(4'b0110, 8'd1);

    // Counter wrap over 257 words.
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    runStream(257, 1'b1);
    check("wrap final count", count0, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
